// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with PC, fetch handshake and IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_IF_ctrl_Stall,
    input  logic        i_IF_ctrl_Redirect,
    input  logic [31:0] i_IF_data_RedirectPC,
    output logic        o_IF_mem_Req,
    output logic [31:0] o_IF_mem_Addr,
    input  logic        i_IF_mem_Ready,
    input  logic [31:0] i_IF_mem_Data,
    output logic [31:0] o_ID_data_instruction,
    output logic [31:0] o_EX_data_PCNext,
    output logic        o_ID_valid
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        xfer;

    // Request is raised whenever the stage is out of reset; it drops with reset
    // so an outstanding fetch is simply abandoned.
    assign o_IF_mem_Req    = nrst;
    assign o_IF_mem_Addr   = pc;
    assign xfer            = o_IF_mem_Req & i_IF_mem_Ready;
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = {i_IF_data_RedirectPC[31:2], 2'b00};

    // Fetch state machine, PC, pending redirect target and IF/ID register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                 <= ST_FETCH;
            pc                    <= {RESET_PC[31:2], 2'b00};
            pending_pc            <= 32'h0;
            o_ID_data_instruction <= 32'h0;
            o_EX_data_PCNext      <= 32'h0;
            o_ID_valid            <= 1'b0;
        end else begin
            case (state)
                ST_FETCH, ST_WAIT: begin
                    if (xfer) begin
                        state <= ST_FETCH;
                        if (i_IF_ctrl_Redirect) begin
                            // Wrong-path instruction in ID: squash it even under stall.
                            pc                    <= redirect_target;
                            o_ID_data_instruction <= 32'h0;
                            o_EX_data_PCNext      <= 32'h0;
                            o_ID_valid            <= 1'b0;
                        end else if (!i_IF_ctrl_Stall) begin
                            pc                    <= pc_plus4;
                            o_ID_data_instruction <= i_IF_mem_Data;
                            o_EX_data_PCNext      <= pc_plus4;
                            o_ID_valid            <= 1'b1;
                        end
                        // Stall with data: word dropped, same PC refetched.
                    end else begin
                        if (i_IF_ctrl_Redirect) begin
                            // Fetch still in flight at the old PC; keep Addr stable
                            // and remember where to go once it returns.
                            state                 <= ST_DRAIN;
                            pending_pc            <= redirect_target;
                            o_ID_data_instruction <= 32'h0;
                            o_EX_data_PCNext      <= 32'h0;
                            o_ID_valid            <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                            if (!i_IF_ctrl_Stall) begin
                                o_ID_data_instruction <= 32'h0;
                                o_EX_data_PCNext      <= 32'h0;
                                o_ID_valid            <= 1'b0;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (xfer) begin
                        // Stale data discarded; a redirect arriving now is the newest target.
                        state <= ST_FETCH;
                        pc    <= i_IF_ctrl_Redirect ? redirect_target : pending_pc;
                    end else if (i_IF_ctrl_Redirect) begin
                        pending_pc <= redirect_target;
                    end
                    if (i_IF_ctrl_Redirect || !i_IF_ctrl_Stall) begin
                        o_ID_data_instruction <= 32'h0;
                        o_EX_data_PCNext      <= 32'h0;
                        o_ID_valid            <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
